// File: rtl/rf_lx_sb.sv
// Register file with load-extract unit, write-to-read bypass and busy scoreboard.
// Latency: reads and extraction are combinational; writes, busy bits and LErr update on the next clk edge.
// Backpressure: none; every cycle accepts one write and one busy-set, and a misaligned half load is dropped and flagged.
module rf_lx_sb #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RFWr,
  input  logic [AW-1:0]     A3,
  input  logic [DATA_W-1:0] WD,
  input  logic [2:0]        LMode,
  input  logic [1:0]        LOff,
  input  logic              BSet,
  input  logic [AW-1:0]     BAddr,
  input  logic [AW-1:0]     A1,
  input  logic [AW-1:0]     A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              Busy1,
  output logic              Busy2,
  output logic              LErr,
  input  logic [AW-1:0]     reg_sel,
  output logic [DATA_W-1:0] reg_data
);

  localparam logic [2:0] LM_LB  = 3'b001;
  localparam logic [2:0] LM_LBU = 3'b010;
  localparam logic [2:0] LM_LH  = 3'b011;
  localparam logic [2:0] LM_LHU = 3'b100;
  localparam bit         BYP    = (BYPASS != 0);

  logic [DATA_W-1:0] rf [NREG];
  logic [NREG-1:0]   busy;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] ext;
  logic              mis;
  logic              we;
  logic              bset_ok;

  assign byte_lane = WD[{LOff, 3'b000} +: 8];
  assign half_lane = WD[{LOff[1], 4'b0000} +: 16];

  // Half loads need an even byte offset; an odd one is treated as misaligned.
  assign mis     = ((LMode == LM_LH) || (LMode == LM_LHU)) && LOff[0];
  assign we      = RFWr && (A3 != '0) && !mis;
  assign bset_ok = BSet && (BAddr != '0);

  // Lane select and sign/zero extension of the incoming load word.
  always_comb begin
    ext = WD;
    case (LMode)
      LM_LB:   ext = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      LM_LBU:  ext = {{(DATA_W-8){1'b0}}, byte_lane};
      LM_LH:   ext = {{(DATA_W-16){half_lane[15]}}, half_lane};
      LM_LHU:  ext = {{(DATA_W-16){1'b0}}, half_lane};
      default: ext = WD;
    endcase
  end

  // Register array, scoreboard and misalignment flag; a busy-set lands after the write clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      busy <= '0;
      LErr <= 1'b0;
    end else begin
      if (we) begin
        rf[A3]   <= ext;
        busy[A3] <= 1'b0;
      end
      if (bset_ok) busy[BAddr] <= 1'b1;
      LErr <= mis;
    end
  end

  // Read port 1 with optional same-cycle bypass of the extracted value.
  always_comb begin
    RD1   = rf[A1];
    Busy1 = busy[A1];
    if (A1 == '0) begin
      RD1   = '0;
      Busy1 = 1'b0;
    end else if (BYP && we && (A3 == A1)) begin
      RD1 = ext;
      if (!(bset_ok && (BAddr == A1))) Busy1 = 1'b0;
    end
  end

  // Read port 2, same rules as port 1.
  always_comb begin
    RD2   = rf[A2];
    Busy2 = busy[A2];
    if (A2 == '0) begin
      RD2   = '0;
      Busy2 = 1'b0;
    end else if (BYP && we && (A3 == A2)) begin
      RD2 = ext;
      if (!(bset_ok && (BAddr == A2))) Busy2 = 1'b0;
    end
  end

  // Debug port for the board display shows stored state only.
  assign reg_data = (reg_sel == '0) ? '0 : rf[reg_sel];

`ifndef SYNTHESIS
  // Simulation trace of each committed write.
  always_ff @(posedge clk) begin
    if (!rst && we) $display("rf_lx_sb: r%0d <= %h", A3, ext);
  end
`endif

endmodule

// File: tb/tb_rf_lx_sb.sv
module tb_rf_lx_sb;

  logic        clk;
  logic        rst;
  logic        RFWr, BSet;
  logic [4:0]  A3, BAddr, A1, A2, reg_sel;
  logic [31:0] WD;
  logic [2:0]  LMode;
  logic [1:0]  LOff;

  logic [31:0] RD1_a, RD2_a, reg_data_a, RD1_b, RD2_b, reg_data_b;
  logic        Busy1_a, Busy2_a, LErr_a, Busy1_b, Busy2_b, LErr_b;

  logic        w_RFWr, w_BSet;
  logic [3:0]  w_A3, w_BAddr, w_A1, w_A2, w_reg_sel;
  logic [63:0] w_WD;
  logic [2:0]  w_LMode;
  logic [1:0]  w_LOff;
  logic [63:0] w_RD1, w_RD2, w_reg_data;
  logic        w_Busy1, w_Busy2, w_LErr;

  int vectors;
  int miscompares;

  rf_lx_sb u0 (
    .clk(clk), .rst(rst), .RFWr(RFWr), .A3(A3), .WD(WD), .LMode(LMode), .LOff(LOff),
    .BSet(BSet), .BAddr(BAddr), .A1(A1), .A2(A2), .RD1(RD1_a), .RD2(RD2_a),
    .Busy1(Busy1_a), .Busy2(Busy2_a), .LErr(LErr_a), .reg_sel(reg_sel), .reg_data(reg_data_a)
  );

  rf_lx_sb #(.BYPASS(0)) u1 (
    .clk(clk), .rst(rst), .RFWr(RFWr), .A3(A3), .WD(WD), .LMode(LMode), .LOff(LOff),
    .BSet(BSet), .BAddr(BAddr), .A1(A1), .A2(A2), .RD1(RD1_b), .RD2(RD2_b),
    .Busy1(Busy1_b), .Busy2(Busy2_b), .LErr(LErr_b), .reg_sel(reg_sel), .reg_data(reg_data_b)
  );

  rf_lx_sb #(.DATA_W(64), .NREG(16)) u2 (
    .clk(clk), .rst(rst), .RFWr(w_RFWr), .A3(w_A3), .WD(w_WD), .LMode(w_LMode), .LOff(w_LOff),
    .BSet(w_BSet), .BAddr(w_BAddr), .A1(w_A1), .A2(w_A2), .RD1(w_RD1), .RD2(w_RD2),
    .Busy1(w_Busy1), .Busy2(w_Busy2), .LErr(w_LErr), .reg_sel(w_reg_sel), .reg_data(w_reg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RFWr = 1'b0; BSet = 1'b0; LMode = 3'd0; LOff = 2'd0;
    w_RFWr = 1'b0; w_BSet = 1'b0; w_LMode = 3'd0; w_LOff = 2'd0;
  endtask

  // extraction table for WD = 0x80FF7F01 (bytes 01, 7F, FF, 80)
  logic [2:0]  x_mode [12] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd1, 3'd5, 3'd0, 3'd7, 3'd2};
  logic [1:0]  x_off  [12] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1, 2'd2, 2'd2};
  logic [31:0] x_exp  [12] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF,
                               32'h00007F01, 32'h000080FF, 32'h00007F01, 32'h00000001,
                               32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h000000FF};

  // 64-bit extraction table for WD = 0x1122334480FF7F80
  logic [2:0]  y_mode [5] = '{3'd1, 3'd1, 3'd3, 3'd4, 3'd0};
  logic [1:0]  y_off  [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd3};
  logic [63:0] y_exp  [5] = '{64'hFFFFFFFFFFFFFF80, 64'h000000000000007F, 64'hFFFFFFFFFFFF80FF,
                              64'h0000000000007F80, 64'h1122334480FF7F80};

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    A3 = '0; BAddr = '0; A1 = '0; A2 = '0; reg_sel = '0; WD = '0;
    w_A3 = '0; w_BAddr = '0; w_A1 = '0; w_A2 = '0; w_reg_sel = '0; w_WD = '0;
    idle();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_rd1", RD1_a, 0);
    chk("reset_lerr", LErr_a, 0);
    chk("reset_w_rd1", w_RD1, 0);

    // reset overrides a same-cycle write and busy-set
    RFWr = 1'b1; A3 = 5'd5; WD = 32'h12345678;
    tick();
    idle(); reg_sel = 5'd5;
    #1;
    chk("pre_reset_r5", reg_data_a, 32'h12345678);
    rst = 1'b1; RFWr = 1'b1; A3 = 5'd5; WD = 32'hCAFEF00D; BSet = 1'b1; BAddr = 5'd5;
    tick();
    rst = 1'b0; idle(); A1 = 5'd5; A2 = 5'd5;
    #1;
    chk("rst_r5_rd1", RD1_a, 0);
    chk("rst_r5_dbg", reg_data_a, 0);
    chk("rst_busy1", Busy1_a, 0);
    chk("rst_busy2", Busy2_a, 0);
    chk("rst_lerr", LErr_a, 0);

    // extraction, observed through bypass before the edge and debug port after
    reg_sel = 5'd7; A1 = 5'd7;
    for (int i = 0; i < 12; i++) begin
      RFWr = 1'b1; A3 = 5'd7; WD = 32'h80FF7F01; LMode = x_mode[i]; LOff = x_off[i];
      #1;
      chk("ext_bypass", RD1_a, x_exp[i]);
      tick();
      idle();
      #1;
      chk("ext_stored", reg_data_a, x_exp[i]);
    end

    // misaligned half loads are dropped and flagged for one cycle
    RFWr = 1'b1; A3 = 5'd3; WD = 32'h0000000A; A1 = 5'd3;
    tick();
    RFWr = 1'b1; A3 = 5'd3; WD = 32'h1234FFFF; LMode = 3'd3; LOff = 2'd1;
    #1;
    chk("mis_no_bypass", RD1_a, 32'h0000000A);
    tick();
    idle();
    #1;
    chk("mis_r3_kept", RD1_a, 32'h0000000A);
    chk("mis_lerr_set", LErr_a, 1);
    tick();
    chk("mis_lerr_clear", LErr_a, 0);
    RFWr = 1'b1; A3 = 5'd3; WD = 32'h55667788; LMode = 3'd4; LOff = 2'd3;
    tick();
    idle();
    #1;
    chk("mis_lhu_r3", RD1_a, 32'h0000000A);
    chk("mis_lhu_lerr", LErr_a, 1);

    // bypass on vs off
    RFWr = 1'b1; A3 = 5'd9; WD = 32'hDEADBEEF; A1 = 5'd9;
    #1;
    chk("byp_on_rd1", RD1_a, 32'hDEADBEEF);
    chk("byp_off_rd1", RD1_b, 32'h00000000);
    tick();
    idle();
    #1;
    chk("byp_off_after", RD1_b, 32'hDEADBEEF);

    // scoreboard
    BSet = 1'b1; BAddr = 5'd4; A1 = 5'd4; A2 = 5'd4;
    #1;
    chk("sb_pre_set", Busy1_a, 0);
    tick();
    chk("sb_set", Busy1_a, 1);
    tick();
    idle();
    #1;
    chk("sb_reset_again", Busy1_a, 1);
    RFWr = 1'b1; A3 = 5'd4; WD = 32'h00000044;
    #1;
    chk("sb_byp_busy2", Busy2_a, 0);
    chk("sb_nobyp_busy2", Busy2_b, 1);
    tick();
    idle();
    #1;
    chk("sb_write_clear", Busy1_a, 0);
    chk("sb_write_data", RD1_a, 32'h00000044);
    RFWr = 1'b1; A3 = 5'd4; WD = 32'h00000045; BSet = 1'b1; BAddr = 5'd4;
    tick();
    idle();
    #1;
    chk("sb_write_and_set", Busy1_a, 1);
    chk("sb_write_and_set_d", RD1_a, 32'h00000045);
    BSet = 1'b1; BAddr = 5'd0; A1 = 5'd0;
    tick();
    idle();
    #1;
    chk("sb_r0_busy", Busy1_a, 0);

    // register 0
    RFWr = 1'b1; A3 = 5'd0; WD = 32'hFFFFFFFF; A1 = 5'd0; reg_sel = 5'd0;
    #1;
    chk("r0_bypass", RD1_a, 0);
    tick();
    idle();
    #1;
    chk("r0_rd1", RD1_a, 0);
    chk("r0_dbg", reg_data_a, 0);

    // 64-bit / 16-register instance
    w_A1 = 4'd7; w_reg_sel = 4'd7;
    for (int i = 0; i < 5; i++) begin
      w_RFWr = 1'b1; w_A3 = 4'd7; w_WD = 64'h1122334480FF7F80; w_LMode = y_mode[i]; w_LOff = y_off[i];
      #1;
      chk("w_ext_bypass", w_RD1, y_exp[i]);
      tick();
      idle();
      #1;
      chk("w_ext_stored", w_reg_data, y_exp[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
